keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the 4x3 telephone-style keypad matrix: scans columns, synchronizes and debounces the row returns, and emits one single-cycle strobe per accepted key press.
- The strobes are num0..num9, star and sharp. They feed the four-digit entry and encrypt/decrypt datapath, which consumes them as one-clock pulses.
- Also presents an encoded key_code/key_valid pair for other consumers.

Parameters:
- SCAN_DIV, 4, clock cycles each column is driven; must be >= 3.
- DEBOUNCE_FRAMES, 3, consecutive identical full-scan frames required to accept a press, and consecutive empty frames to accept a release; 1..15.
- REPEAT_FRAMES, 8, frames between repeat strobes; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous and active-high. One clock; reset is asynchronous and active-high.
- row  input  4  matrix rows, active-low (external pull-ups)
- col  output  3  matrix column drive, active-low, one-cold
- num0..num9  output  1 each  single-cycle digit strobes
- star  output  1  single-cycle '*' strobe
- sharp  output  1  single-cycle '#' strobe
- key_code  output  4  code of the last accepted key: 0-9 digits, 10 '*', 11 '#'
- key_valid  output  1  high for the same cycle as any strobe

Behaviour:
- Reset values: col=3'b110, all strobes 0, key_valid 0, key_code 0, state IDLE, all counters 0. Reset mid-operation discards candidate and counts; no strobe is generated by a press in progress at reset.
- Keymap (row,col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- row passes through a 2-flop synchronizer before any use.
- Column timing:
  - A dwell counter runs 0..SCAN_DIV-1; col rotates 110 -> 101 -> 011 -> 110 when the counter wraps.
  - The synchronized row is sampled on the last dwell cycle of each column.
  - One frame = 3*SCAN_DIV cycles.
- Frame result is evaluated at the last cycle of column 2. It is NONE (no active row seen), SINGLE(k) (exactly one active row/column intersection in the frame), or MULTI (two or more).
- FSM, advanced only at frame end:
  - IDLE: SINGLE(k) -> DEBOUNCE with cand=k, cnt=1. NONE or MULTI -> stay.
  - DEBOUNCE:
    - SINGLE(cand) -> cnt+1.
    - When cnt reaches DEBOUNCE_FRAMES: fire, go to HELD with rcnt=0.
    - Any other result -> IDLE.
    - If DEBOUNCE_FRAMES=1, IDLE fires directly on SINGLE(k).
  - HELD:
    - NONE -> rcnt+1; at DEBOUNCE_FRAMES -> IDLE.
    - SINGLE or MULTI -> rcnt=0.
    - No further strobes while held.
- Fire action:
  - In the cycle after frame end, exactly one strobe matching cand is high for 1 cycle, with key_valid high.
  - key_code=cand, updated in the same cycle and held until the next fire.
- A key change during HELD (releasing one key and pressing another with no empty frames between) produces no strobe. A full release must be debounced first.
- Strobes are mutually exclusive; at most one output strobe is high in any cycle.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- When defined:
  - In HELD, a repeat counter counts SINGLE(cand) frames.
  - Every REPEAT_FRAMES such frames, the fire action repeats for cand.
  - Any non-matching frame clears the repeat counter.
- When undefined: the repeat logic is absent and HELD never strobes.

Decomposition:
- Package keypad_pkg:
  - key code constants KEY_0..KEY_9, KEY_STAR=10, KEY_SHARP=11
  - state enum {IDLE, DEBOUNCE, HELD}
  - frame-result enum {NONE, SINGLE, MULTI}
  - column-drive constant 3'b110
- One sub-module, keypad_sync: parameterized-width 2-flop synchronizer with asynchronous active-high reset, instantiated on row.
- Decode, FSM and strobe generation stay in keypad_scanner.

Test Plan:
Bench setup: SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=12 cycles. The matrix model pulls row[r] low while col[c]=0 and key (r,c) is pressed. Cycle 0 = first edge after rst falls.
1. Hold '5' from cycle 0 -> num5 high for exactly 1 cycle at cycle 36, key_code=5, key_valid=1. No other strobe for a further 10 frames of holding.
2. Press '*' for 1 frame, release 1 frame, press again 1 frame -> no strobe. Then hold '#' 3 frames -> single sharp pulse at the following frame-end+1, key_code=11.
3. Hold '1' and '9' together for 6 frames -> no strobe, key_valid stays 0. Release '9' while '1' stays held -> num1 strobe 3 frames later.
4. Accept '4'; release 2 frames, re-press '4' 3 frames -> no second strobe. Release 3 frames, re-press 3 frames -> second num4 strobe.
5. Assert rst at cycle 30 while '8' is held from cycle 0 -> col=110 and outputs 0 immediately (asynchronous). After release, strobe num8 arrives 36 cycles later with no earlier strobe.
6. With KEYPAD_AUTOREPEAT_EN defined and '2' held 30 frames -> num2 at frame 3, then every 8 frames (frames 11, 19, 27). Without the macro -> one strobe only.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, FSM/frame enums and keymap helpers for keypad_scanner
//
// Contents:
//   KEY_0..KEY_9, KEY_STAR, KEY_SHARP  4-bit key codes (digits 0-9, '*'=10, '#'=11)
//   COL_FIRST                          column drive for column 0 (active-low, one-cold)
//   state_t                            IDLE / DEBOUNCE / HELD
//   frame_t                            NONE / SINGLE / MULTI frame result
//   key_at(r, c)                       key code at matrix row r, column c
//   key_onehot(k)                      12-bit one-hot strobe vector for key code k
package keypad_pkg;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_SHARP = 4'd11;

    localparam logic [2:0] COL_FIRST = 3'b110;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_t;

    function automatic logic [3:0] key_at(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = KEY_1;
            4'b00_01: k = KEY_2;
            4'b00_10: k = KEY_3;
            4'b01_00: k = KEY_4;
            4'b01_01: k = KEY_5;
            4'b01_10: k = KEY_6;
            4'b10_00: k = KEY_7;
            4'b10_01: k = KEY_8;
            4'b10_10: k = KEY_9;
            4'b11_00: k = KEY_STAR;
            4'b11_01: k = KEY_0;
            4'b11_10: k = KEY_SHARP;
            default:  k = KEY_0;
        endcase
        return k;
    endfunction

    function automatic logic [11:0] key_onehot(input logic [3:0] k);
        return 12'b1 << k;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - parameterized-width two-flop synchronizer with asynchronous active-high reset
//
// Ports:
//   clk  input          destination clock
//   rst  input          asynchronous active-high reset (loads RESET_VAL)
//   d    input  [W-1:0] asynchronous input
//   q    output [W-1:0] synchronized output
module keypad_sync #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with debounce and single-cycle key strobes
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (repeat strobes every REPEAT_FRAMES held frames).
//
// Ports:
//   clk        input       system clock
//   rst        input       asynchronous active-high reset
//   row        input  [3]  matrix rows, active-low
//   col        output [2]  column drive, active-low, one-cold
//   num0..num9 output      digit strobes (one cycle)
//   star/sharp output      '*' / '#' strobes (one cycle)
//   key_code   output [3]  code of last accepted key (held until next accept)
//   key_valid  output      high with any strobe
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_FRAMES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [2:0] col,
    output logic       num0,
    output logic       num1,
    output logic       num2,
    output logic       num3,
    output logic       num4,
    output logic       num5,
    output logic       num6,
    output logic       num7,
    output logic       num8,
    output logic       num9,
    output logic       star,
    output logic       sharp,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int            DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]    DB_LAST    = 4'(DEBOUNCE_FRAMES);

    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || REPEAT_FRAMES < 1) begin : g_bad_cfg
        $error("keypad_scanner: parameter out of range");
    end

    logic [3:0] row_s;

    keypad_sync #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    // Scan bookkeeping
    logic [DW-1:0] dwell;
    logic [1:0]    acc_cnt;   // intersections seen so far this frame, saturating at 2
    logic [3:0]    acc_key;   // key of the single intersection seen so far
    logic          dwell_end;
    logic          frame_end;
    logic [1:0]    col_idx;
    logic [3:0]    act;
    logic [2:0]    hits;
    logic [1:0]    hit_row;
    logic [3:0]    col_key;
    logic [2:0]    tot_raw;
    logic [1:0]    tot;
    frame_t        fres;
    logic [3:0]    fkey;
    logic          match;

    // FSM state
    state_t        state;
    logic [3:0]    cand;
    logic [3:0]    cnt;
    logic [3:0]    rcnt;
    logic [11:0]   strobe;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES);
    logic [RW-1:0] rep;
`endif

    // The frame result folds in the column being sampled right now, so the
    // last column counts in the same cycle the frame closes.
    always_comb begin
        dwell_end = (dwell == DWELL_LAST);
        frame_end = dwell_end && (col == 3'b011);
        case (col)
            3'b110:  col_idx = 2'd0;
            3'b101:  col_idx = 2'd1;
            default: col_idx = 2'd2;
        endcase
        act     = ~row_s;
        hits    = {2'b00, act[0]} + {2'b00, act[1]} + {2'b00, act[2]} + {2'b00, act[3]};
        hit_row = act[0] ? 2'd0 : act[1] ? 2'd1 : act[2] ? 2'd2 : 2'd3;
        col_key = key_at(hit_row, col_idx);
        tot_raw = {1'b0, acc_cnt} + ((hits > 3'd1) ? 3'd2 : hits);
        tot     = (tot_raw > 3'd1) ? 2'd2 : tot_raw[1:0];
        fkey    = (hits == 3'd1) ? col_key : acc_key;
        case (tot)
            2'd0:    fres = NONE;
            2'd1:    fres = SINGLE;
            default: fres = MULTI;
        endcase
        match = (fres == SINGLE) && (fkey == cand);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col     <= COL_FIRST;
            acc_cnt <= 2'd0;
            acc_key <= 4'd0;
        end else if (dwell_end) begin
            dwell <= '0;
            col   <= {col[1:0], col[2]};
            if (frame_end) begin
                acc_cnt <= 2'd0;
                acc_key <= 4'd0;
            end else begin
                acc_cnt <= tot;
                if (hits == 3'd1) begin
                    acc_key <= col_key;
                end
            end
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= 4'd0;
            rcnt      <= 4'd0;
            strobe    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep       <= '0;
`endif
        end else begin
            strobe    <= '0;
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: begin
                        if (fres == SINGLE) begin
                            cand <= fkey;
                            if (DB_LAST == 4'd1) begin
                                strobe    <= key_onehot(fkey);
                                key_valid <= 1'b1;
                                key_code  <= fkey;
                                rcnt      <= 4'd0;
                                state     <= HELD;
                            end else begin
                                cnt   <= 4'd1;
                                state <= DEBOUNCE;
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (match) begin
                            if (cnt + 4'd1 == DB_LAST) begin
                                strobe    <= key_onehot(cand);
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                cnt       <= 4'd0;
                                rcnt      <= 4'd0;
                                state     <= HELD;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cnt   <= 4'd0;
                            state <= IDLE;
                        end
                    end
                    HELD: begin
                        // Only a run of empty frames releases; any key activity
                        // (including a different key) restarts the release count.
                        if (fres == NONE) begin
                            if (rcnt + 4'd1 == DB_LAST) begin
                                rcnt  <= 4'd0;
                                state <= IDLE;
                            end else begin
                                rcnt <= rcnt + 4'd1;
                            end
                        end else begin
                            rcnt <= 4'd0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        if (match) begin
                            if (rep + 1'b1 == REP_LAST) begin
                                rep       <= '0;
                                strobe    <= key_onehot(cand);
                                key_valid <= 1'b1;
                                key_code  <= cand;
                            end else begin
                                rep <= rep + 1'b1;
                            end
                        end else begin
                            rep <= '0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
`ifdef KEYPAD_AUTOREPEAT_EN
                if (state != HELD) begin
                    rep <= '0;
                end
`endif
            end
        end
    end

    assign {sharp, star, num9, num8, num7, num6, num5, num4, num3, num2, num1, num0} = strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a frame-level reference model
module tb_keypad_scanner;

    localparam int FRAME = 12;
    localparam int DF    = 3;
    localparam int RF    = 8;
    localparam int CODE_AT [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [2:0] col;
    logic       num0, num1, num2, num3, num4, num5, num6, num7, num8, num9;
    logic       star, sharp;
    logic [3:0] key_code;
    logic       key_valid;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(DF), .REPEAT_FRAMES(RF)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col),
        .num0(num0), .num1(num1), .num2(num2), .num3(num3), .num4(num4),
        .num5(num5), .num6(num6), .num7(num7), .num8(num8), .num9(num9),
        .star(star), .sharp(sharp), .key_code(key_code), .key_valid(key_valid)
    );

    // Pressed-key set, indexed by key code; the matrix pulls a row low when
    // any pressed key on that row sits on the driven column.
    logic [11:0] keys = '0;
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (keys[CODE_AT[r][c]] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    int          asserts = 0;
    int          fails   = 0;
    int          cyc     = 0;
    bit          chk     = 1'b0;
    logic [11:0] exp_vec = '0;
    logic        exp_valid = 1'b0;
    logic [3:0]  exp_code = 4'd0;
    logic [11:0] cur_keys = '0;
    int          events[$];
    int          want[$];

    // Reference model state, in terms of frames
    bit held;
    int streak, cand, rel, rep;

    function automatic logic [11:0] kb(input int k);
        return 12'b1 << k;
    endfunction

    task automatic model_reset();
        held = 1'b0; streak = 0; cand = 0; rel = 0; rep = 0;
        exp_vec = '0; exp_valid = 1'b0; exp_code = 4'd0;
    endtask

    // One full frame with pressed set ks has just ended.
    task automatic model_frame(input logic [11:0] ks);
        int n;
        int k;
        bit single;
        bit fire;
        n = $countones(ks);
        k = -1;
        for (int i = 0; i < 12; i++) if (ks[i]) k = i;
        single = (n == 1);
        fire = 1'b0;
        if (!held) begin
            if (streak > 0 && single && k == cand) streak++;
            else if (streak > 0) streak = 0;
            else if (single) begin cand = k; streak = 1; end
            if (streak == DF) begin fire = 1'b1; held = 1'b1; streak = 0; rel = 0; rep = 0; end
        end else begin
            if (n == 0) begin
                rel++;
                if (rel == DF) begin held = 1'b0; rel = 0; end
            end else rel = 0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (single && k == cand) begin
                rep++;
                if (rep == RF) begin fire = 1'b1; rep = 0; end
            end else rep = 0;
`endif
        end
        if (fire) begin
            exp_vec = kb(cand); exp_valid = 1'b1; exp_code = 4'(cand);
        end
    endtask

    // Cycle-by-cycle compare against the model
    logic [11:0] cmp_v;
    int          cmp_k;
    always @(negedge clk) begin
        if (chk) begin
            cmp_v = {sharp, star, num9, num8, num7, num6, num5, num4, num3, num2, num1, num0};
            asserts += 3;
            if (cmp_v !== exp_vec) begin
                fails++;
                $display("FAIL strobes cycle %0d: got %b want %b", cyc, cmp_v, exp_vec);
            end
            if (key_valid !== exp_valid) begin
                fails++;
                $display("FAIL key_valid cycle %0d: got %b want %b", cyc, key_valid, exp_valid);
            end
            if (key_code !== exp_code) begin
                fails++;
                $display("FAIL key_code cycle %0d: got %0d want %0d", cyc, key_code, exp_code);
            end
            if (cmp_v != '0) begin
                cmp_k = 0;
                for (int i = 0; i < 12; i++) if (cmp_v[i]) cmp_k = i;
                events.push_back(cyc * 16 + cmp_k);
            end
        end
    end

    // Hold ks for ncyc cycles; the set may only change at frame starts.
    task automatic step(input logic [11:0] ks, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            exp_vec = '0; exp_valid = 1'b0;
            if (cyc % FRAME == 0) begin
                if (cyc > 0) model_frame(cur_keys);
                cur_keys = ks;
            end
            keys = cur_keys;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        chk = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        asserts += 4;
        if (col !== 3'b110) begin fails++; $display("FAIL reset col: got %b want 110", col); end
        if ({sharp, star, num9, num8, num7, num6, num5, num4, num3, num2, num1, num0} !== 12'd0) begin
            fails++; $display("FAIL reset strobes: got nonzero want 0");
        end
        if (key_valid !== 1'b0) begin fails++; $display("FAIL reset key_valid: got %b want 0", key_valid); end
        if (key_code !== 4'd0) begin fails++; $display("FAIL reset key_code: got %0d want 0", key_code); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        model_reset();
        events.delete();
        chk = 1'b1;
    endtask

    task automatic check_events(input string name);
        asserts++;
        if (events.size() != want.size()) begin
            fails++;
            $display("FAIL %s strobe count: got %0d want %0d", name, events.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                asserts++;
                if (events[i] != want[i]) begin
                    fails++;
                    $display("FAIL %s strobe %0d: got cycle %0d code %0d, want cycle %0d code %0d",
                             name, i, events[i] / 16, events[i] % 16, want[i] / 16, want[i] % 16);
                end
            end
        end
    endtask

    initial begin
        logic [11:0] ks;
        int k1, k2, sel;

        // 1: hold '5'
        do_reset();
        step(kb(5), 13 * FRAME);
        step('0, 4 * FRAME);
        want = '{36 * 16 + 5};
        check_events("hold5");

        // 2: short '*' taps, then '#'
        do_reset();
        step(kb(10), FRAME); step('0, FRAME); step(kb(10), FRAME); step('0, FRAME);
        step(kb(11), 3 * FRAME); step('0, 4 * FRAME);
        want = '{84 * 16 + 11};
        check_events("sharp");
        asserts++;
        if (key_code !== 4'd11) begin fails++; $display("FAIL sharp key_code hold: got %0d want 11", key_code); end

        // 3: '1' and '9' together, then '1' alone
        do_reset();
        step(kb(1) | kb(9), 6 * FRAME); step(kb(1), 4 * FRAME); step('0, 4 * FRAME);
        want = '{108 * 16 + 1};
        check_events("multi");

        // 4: partial release does not re-arm
        do_reset();
        step(kb(4), 3 * FRAME); step('0, 2 * FRAME); step(kb(4), 3 * FRAME);
        step('0, 3 * FRAME); step(kb(4), 3 * FRAME); step('0, 4 * FRAME);
        want = '{36 * 16 + 4, 168 * 16 + 4};
        check_events("rearm");

        // 5: reset during a press
        do_reset();
        step(kb(8), 30);
        want.delete();
        check_events("pre_reset");
        do_reset();
        step(kb(8), 4 * FRAME); step('0, 4 * FRAME);
        want = '{36 * 16 + 8};
        check_events("post_reset");

        // 6: long hold of '2'
        do_reset();
        step(kb(2), 30 * FRAME); step('0, 4 * FRAME);
`ifdef KEYPAD_AUTOREPEAT_EN
        want = '{36 * 16 + 2, 132 * 16 + 2, 228 * 16 + 2, 324 * 16 + 2};
`else
        want = '{36 * 16 + 2};
`endif
        check_events("long_hold");

        // 7: randomized press patterns against the model
        for (int run = 0; run < 3; run++) begin
            do_reset();
            for (int seg = 0; seg < 40; seg++) begin
                sel = $urandom_range(0, 9);
                k1 = $urandom_range(0, 11);
                k2 = (k1 + 1 + $urandom_range(0, 10)) % 12;
                if (sel < 2) ks = '0;
                else if (sel < 8) ks = kb(k1);
                else ks = kb(k1) | kb(k2);
                step(ks, $urandom_range(1, 5) * FRAME);
            end
            step('0, 4 * FRAME);
        end

        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
